// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel scan/direct multiplexer.
package mux_pkg;

    // Operating modes of the channel selector.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest concatenated input bus the slice helper accepts (N_CH*DATA_W).
    localparam int MAX_BUS_W = 1024;

    // Return channel idx of a packed bus of data_w-wide channels, right-aligned
    // and zero-extended; the caller keeps the low data_w bits.
    function automatic logic [MAX_BUS_W-1:0] ch_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          data_w
    );
        logic [MAX_BUS_W-1:0] mask;
        mask = ~({MAX_BUS_W{1'b1}} << data_w);
        return (bus >> (idx * data_w)) & mask;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Round-robin next-channel finder: first enabled channel at or after scan_ptr,
// wrapping from N_CH-1 back to 0.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter  int N_CH  = 16,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  ch_en,
    input  logic [SEL_W-1:0] scan_ptr,
    output logic [SEL_W-1:0] nxt,
    output logic             any_en
);

    logic [N_CH-1:0]  rot_s;
    logic [SEL_W-1:0] off_s;
    logic [SEL_W:0]   sum_s;

    // Rotate enables so that bit 0 corresponds to the channel at scan_ptr.
    // scan_ptr is always < N_CH, so the doubled vector covers the wrap.
    always_comb begin
        rot_s = N_CH'({ch_en, ch_en} >> scan_ptr);
    end

    // Priority encoder: offset of the lowest set bit of the rotated enables.
    always_comb begin
        off_s = {SEL_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? SEL_W'(i) : off_s;
        end
    end

    // Undo the rotation: (scan_ptr + offset) mod N_CH.
    always_comb begin
        sum_s  = {1'b0, scan_ptr} + {1'b0, off_s};
        nxt    = (sum_s >= (SEL_W+1)'(N_CH)) ? SEL_W'(sum_s - (SEL_W+1)'(N_CH))
                                              : SEL_W'(sum_s);
        any_en = |ch_en;
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel registered multiplexer with valid/ready output stage.
// DIRECT mode picks the channel from sel_in; SCAN mode walks the enabled
// channels round-robin. The output register only loads in a capture slot
// (!out_valid | out_ready), so a stalled sample is never replaced.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter  int N_CH   = 16,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [N_CH-1:0]        ch_en,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err
);

    logic [DATA_W-1:0]    data_q,  data_d;
    logic [SEL_W-1:0]     ch_q,    ch_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;
    logic [SEL_W-1:0]     ptr_q,   ptr_d;

    logic                 capture_s;
    logic                 sel_oor_s;
    logic [SEL_W-1:0]     nxt_s;
    logic                 any_en_s;
    logic [SEL_W-1:0]     load_idx_s;
    logic [DATA_W-1:0]    load_data_s;
    logic [MAX_BUS_W-1:0] bus_ext_s;

    mux_next_ch #(
        .N_CH (N_CH)
    ) u_next_ch (
        .ch_en    (ch_en),
        .scan_ptr (ptr_q),
        .nxt      (nxt_s),
        .any_en   (any_en_s)
    );

    // An out-of-range select only exists when N_CH is not a power of two.
    generate
        if ((1 << SEL_W) == N_CH) begin : g_sel_pow2
            assign sel_oor_s = 1'b0;
        end else begin : g_sel_npow2
            assign sel_oor_s = (32'(sel_in) >= N_CH);
        end
    endgenerate

    assign bus_ext_s = MAX_BUS_W'(in_data);

    // Capture-slot detection and the data word that would be loaded.
    always_comb begin
        capture_s   = ~valid_q | out_ready;
        load_idx_s  = (mode == MODE_DIRECT) ? sel_in : nxt_s;
        load_data_s = DATA_W'(ch_slice(bus_ext_s, 32'(load_idx_s), 32'(DATA_W)));
    end

    // Next-state logic for the output register, error pulse and scan pointer.
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        if (capture_s) begin
            if (mode == MODE_DIRECT) begin
                if (sel_oor_s) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    data_d  = load_data_s;
                    ch_d    = sel_in;
                    valid_d = 1'b1;
                end
            end else begin
                if (any_en_s) begin
                    data_d  = load_data_s;
                    ch_d    = nxt_s;
                    valid_d = 1'b1;
                    ptr_d   = (nxt_s == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}}
                                                          : nxt_s + SEL_W'(1);
                end else begin
                    valid_d = 1'b0;
                end
            end
        end else begin
            data_d  = data_q;
            ch_d    = ch_q;
            valid_d = valid_q;
            ptr_d   = ptr_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {DATA_W{1'b0}};
            ch_q    <= {SEL_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= {SEL_W{1'b0}};
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Self-checking bench for mux_nx1_scan: a 16-channel and a 12-channel build
// share the stimulus and are both compared against a behavioural model.
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] en;
    logic        rdy;
    logic [7:0]  chan [16];

    logic [127:0] in16;
    logic [95:0]  in12;

    logic [7:0] out_data16, out_data12;
    logic [3:0] out_ch16,   out_ch12;
    logic       out_valid16, out_valid12;
    logic       sel_err16,   sel_err12;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         valid;
        logic [7:0] data;
        int         ch;
        int         ptr;
        bit         err;
    } mstate_t;

    mstate_t m16, m12;

    typedef struct {
        bit          md;
        logic [3:0]  sel;
        logic [15:0] en;
        bit          rdy;
        bit          ev;
        logic [3:0]  ech;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_in16
            assign in16[g*8 +: 8] = chan[g];
        end
        for (g = 0; g < 12; g++) begin : g_in12
            assign in12[g*8 +: 8] = chan[g];
        end
    endgenerate

    mux_nx1_scan #(.N_CH(16), .DATA_W(8)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in16),
        .mode      (mode),
        .sel_in    (sel),
        .ch_en     (en),
        .out_data  (out_data16),
        .out_ch    (out_ch16),
        .out_valid (out_valid16),
        .out_ready (rdy),
        .sel_err   (sel_err16)
    );

    mux_nx1_scan #(.N_CH(12), .DATA_W(8)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in12),
        .mode      (mode),
        .sel_in    (sel),
        .ch_en     (en[11:0]),
        .out_data  (out_data12),
        .out_ch    (out_ch12),
        .out_valid (out_valid12),
        .out_ready (rdy),
        .sel_err   (sel_err12)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge of an n-channel mux.
    function automatic mstate_t model_next(mstate_t s, int n, bit md, int sl,
                                           logic [15:0] e, bit r);
        mstate_t nx;
        bit      found;
        int      c;
        nx     = s;
        nx.err = 1'b0;
        found  = 1'b0;
        if (!s.valid || r) begin
            if (!md) begin
                if (sl >= n) begin
                    nx.valid = 1'b0;
                    nx.err   = 1'b1;
                end else begin
                    nx.valid = 1'b1;
                    nx.ch    = sl;
                    nx.data  = chan[sl];
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    c = (s.ptr + k) % n;
                    if (!found && e[c]) begin
                        found    = 1'b1;
                        nx.valid = 1'b1;
                        nx.ch    = c;
                        nx.data  = chan[c];
                        nx.ptr   = (c + 1) % n;
                    end
                end
                if (!found) nx.valid = 1'b0;
            end
        end
        return nx;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.valid = 1'b0;
        s.data  = 8'h00;
        s.ch    = 0;
        s.ptr   = 0;
        s.err   = 1'b0;
        return s;
    endfunction

    task automatic check_models();
        chk("d16_valid", 32'(out_valid16), 32'(m16.valid));
        chk("d16_data",  32'(out_data16),  32'(m16.data));
        chk("d16_ch",    32'(out_ch16),    32'(m16.ch));
        chk("d16_err",   32'(sel_err16),   32'(m16.err));
        chk("d12_valid", 32'(out_valid12), 32'(m12.valid));
        chk("d12_data",  32'(out_data12),  32'(m12.data));
        chk("d12_ch",    32'(out_ch12),    32'(m12.ch));
        chk("d12_err",   32'(sel_err12),   32'(m12.err));
    endtask

    // One clock: predict from the current inputs, take the edge, compare.
    task automatic step();
        mstate_t n16, n12;
        n16 = model_next(m16, 16, mode, int'(sel), en, rdy);
        n12 = model_next(m12, 12, mode, int'(sel), en & 16'h0FFF, rdy);
        @(posedge clk);
        #1;
        m16 = n16;
        m12 = n12;
        check_models();
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m16 = model_reset();
        m12 = model_reset();
        chk("rst_valid16", 32'(out_valid16), 32'd0);
        chk("rst_data16",  32'(out_data16),  32'd0);
        chk("rst_ch16",    32'(out_ch16),    32'd0);
        chk("rst_err16",   32'(sel_err16),   32'd0);
        chk("rst_valid12", 32'(out_valid12), 32'd0);
        chk("rst_data12",  32'(out_data12),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         expect_next;
        int         n_acc;
        logic [3:0] pat;
        int         r;

        rst_n = 1'b1;
        mode  = 1'b0;
        sel   = 4'd0;
        en    = 16'h0000;
        rdy   = 1'b1;
        for (int k = 0; k < 16; k++) chan[k] = 8'hA0 + 8'(k);
        m16 = model_reset();
        m12 = model_reset();
        #2;
        do_reset();

        // mode, sel, en, rdy -> expected valid, ch, data on the 16-channel build
        tbl[0]  = '{1'b0, 4'd5, 16'h0000, 1'b1, 1'b1, 4'd5,  8'hA5};
        tbl[1]  = '{1'b0, 4'd9, 16'h0000, 1'b0, 1'b1, 4'd5,  8'hA5};
        tbl[2]  = '{1'b0, 4'd9, 16'h0000, 1'b0, 1'b1, 4'd5,  8'hA5};
        tbl[3]  = '{1'b0, 4'd9, 16'h0000, 1'b1, 1'b1, 4'd9,  8'hA9};
        tbl[4]  = '{1'b1, 4'd0, 16'h8421, 1'b1, 1'b1, 4'd0,  8'hA0};
        tbl[5]  = '{1'b1, 4'd0, 16'h8421, 1'b1, 1'b1, 4'd5,  8'hA5};
        tbl[6]  = '{1'b1, 4'd0, 16'h8421, 1'b1, 1'b1, 4'd10, 8'hAA};
        tbl[7]  = '{1'b1, 4'd0, 16'h8421, 1'b1, 1'b1, 4'd15, 8'hAF};
        tbl[8]  = '{1'b1, 4'd0, 16'h8421, 1'b1, 1'b1, 4'd0,  8'hA0};
        tbl[9]  = '{1'b0, 4'd3, 16'h8421, 1'b1, 1'b1, 4'd3,  8'hA3};
        tbl[10] = '{1'b1, 4'd3, 16'h8421, 1'b1, 1'b1, 4'd5,  8'hA5};
        tbl[11] = '{1'b1, 4'd3, 16'h0000, 1'b1, 1'b0, 4'd5,  8'hA5};
        tbl[12] = '{1'b1, 4'd3, 16'h0001, 1'b1, 1'b1, 4'd0,  8'hA0};

        for (int i = 0; i < 13; i++) begin
            mode = tbl[i].md;
            sel  = tbl[i].sel;
            en   = tbl[i].en;
            rdy  = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid16), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_ch", i),    32'(out_ch16),    32'(tbl[i].ech));
            chk($sformatf("tbl%0d_data", i),  32'(out_data16),  32'(tbl[i].ed));
        end

        // Reset while a sample is stalled: the held sample is discarded.
        mode = 1'b0;
        sel  = 4'd7;
        rdy  = 1'b0;
        step();
        chk("stall_hold_ch", 32'(out_ch16), 32'd0);
        do_reset();

        // Scan backpressure: accepted channels must be 0,1,2,... with no gaps.
        mode        = 1'b1;
        en          = 16'hFFFF;
        pat         = 4'b1001;
        expect_next = 0;
        n_acc       = 0;
        for (int c = 0; c < 24; c++) begin
            rdy = pat[c % 4];
            #1;
            if (out_valid16 && rdy) begin
                chk("bp_order", 32'(out_ch16), 32'(expect_next));
                chk("bp_data",  32'(out_data16), 32'(8'hA0 + 8'(expect_next)));
                expect_next = (expect_next + 1) % 16;
                n_acc++;
            end
            step();
        end
        chk("bp_accept_count", 32'(n_acc), 32'd11);

        // Out-of-range select on the 12-channel build.
        mode = 1'b0;
        rdy  = 1'b1;
        sel  = 4'd13;
        step();
        chk("oor_err12",   32'(sel_err12),   32'd1);
        chk("oor_valid12", 32'(out_valid12), 32'd0);
        sel = 4'd11;
        step();
        chk("ok_err12",   32'(sel_err12),   32'd0);
        chk("ok_valid12", 32'(out_valid12), 32'd1);
        chk("ok_ch12",    32'(out_ch12),    32'd11);
        chk("ok_data12",  32'(out_data12),  32'hAB);

        // Randomised traffic against the model, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 16; k++) chan[k] = 8'($urandom);
            mode = 1'($urandom);
            sel  = 4'($urandom_range(0, 15));
            r    = int'($urandom_range(0, 3));
            if (r == 0)      en = 16'h0000;
            else if (r == 1) en = 16'h0001 << $urandom_range(0, 15);
            else             en = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if (i == 300) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
